lc3b_mem_ctrl: RTL and testbench
================================

Name: lc3b_mem_ctrl

Overview:
- Memory-side counterpart of the MAR path: latches the address driven by the MAR mux into MAR and owns MDR.
- Runs the LC-3b memory handshake (MIO.EN, R.W, DATA.SIZE → R) against a variable-latency memory with ready.
- Handles byte/word write-enable generation and alignment, plus a timeout on memory response.
- Sits between the datapath bus/MAR mux and the memory model; the control FSM waits on `r`.

Parameters:
- TIMEOUT, 15: max ACCESS cycles waiting for mem_ready before aborting; 1..255.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ld_mar  in  1  load MAR from mar_in
- mar_in  in  16  address from MAR mux
- ld_mdr  in  1  load MDR from mdr_in
- mdr_in  in  16  data from bus (write data)
- mio_en  in  1  start/hold memory access
- r_w  in  1  1 = write, 0 = read
- data_size  in  1  1 = word, 0 = byte
- mar  out  16  MAR register
- mdr  out  16  MDR register
- r  out  1  access complete, one-cycle pulse
- busy  out  1  access in progress
- err  out  1  sticky; set on timeout or unaligned word access
- mem_en  out  1  memory request
- mem_addr  out  16  word address: {mar[15:1],1'b0}
- mem_we  out  2  byte write enables [1]=high byte, [0]=low byte
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, valid when mem_ready=1
- mem_ready  in  1  memory completes request this cycle

Behaviour:
- Reset values:
  - mar=0, mdr=0, state=IDLE, r=0, busy=0, err=0, mem_en=0, mem_we=0, timeout counter=0.
  - Reset mid-access aborts immediately; no completion pulse.
- States: IDLE, ACCESS, DONE. Outputs decode from registered state only.
- IDLE:
  - ld_mar loads mar<=mar_in; ld_mdr loads mdr<=mdr_in.
  - mio_en=1 → ACCESS; the r_w and data_size sampled at that edge are latched for the whole access.
  - Counter cleared.
- ACCESS:
  - mem_en=1, busy=1; mem_addr={mar[15:1],0}.
  - Write word: mem_we=2'b11, mem_wdata=mdr.
  - Write byte: mem_we = mar[0] ? 2'b10 : 2'b01, mem_wdata={mdr[7:0],mdr[7:0]}.
  - Read: mem_we=0.
  - ld_mar and ld_mdr are ignored; mar and mdr are frozen.
  - mem_ready=1 → DONE. On a read, mdr<=mem_rdata (full word; byte selection is the datapath's job).
  - Counter increments every ACCESS cycle without mem_ready. If counter==TIMEOUT-1 and mem_ready=0 → DONE with err<=1; mdr is unchanged.
- DONE:
  - r=1 for exactly one cycle; mem_en=0; busy=0.
  - ld_mar and ld_mdr are honoured.
  - Always → IDLE. If mio_en is still 1 in the following IDLE cycle, a new access starts (back-to-back supported; minimum 3 cycles per access).
- Latency: mio_en sampled at edge N, mem_ready=1 in the first ACCESS cycle → r=1 in cycle N+2.
- Unaligned access: data_size=1 with mar[0]=1 at start sets err<=1. The access still proceeds at the aligned address.
- err is sticky until reset.
- Precedence: reset > FSM freeze > ld_mar/ld_mdr. A simultaneous ld_mdr and read completion cannot occur (ld_mdr is ignored in ACCESS).
- mio_en dropped during ACCESS: the access still completes (no cancel).

Test Plan:
- Word read: ld_mar with mar_in=0x3000, mio_en=1, r_w=0, data_size=1; mem_ready after 4 ACCESS cycles with rdata=0xBEEF → mem_addr=0x3000, mdr=0xBEEF, r pulse 1 cycle, err=0.
- Byte write, high byte: mar=0x4001, mdr=0x00A5, r_w=1, data_size=0 → mem_addr=0x4000, mem_we=2'b10, mem_wdata=0xA5A5; r pulse after mem_ready.
- Timeout: TIMEOUT=15, mem_ready held 0 → exactly 15 ACCESS cycles, then r=1, err=1, mdr unchanged; the next access still works.
- Freeze during busy: ld_mar with 0x1234 and ld_mdr with 0x5678 pulsed during ACCESS → mar and mdr unchanged. The same loads in IDLE take effect next cycle.
- Back-to-back reads: mio_en held high with mem_ready=1 immediately → r pulses every 3 cycles; each mdr value matches its mem_rdata.
- Reset mid-access and unaligned word: reset in 2nd ACCESS cycle → next cycle all outputs at reset values, no r. Word read at mar=0x0003 → err=1, mem_addr=0x0002.

Source files
------------

// File: rtl/lc3b_mem_ctrl.sv
// LC-3b memory-side controller: owns MAR/MDR and runs the MIO.EN / R.W / DATA.SIZE -> R
// handshake against a variable-latency memory, with byte-lane enables and a response timeout.
module lc3b_mem_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_mar,
  input  logic [15:0] mar_in,
  input  logic        ld_mdr,
  input  logic [15:0] mdr_in,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic        data_size,
  output logic [15:0] mar,
  output logic [15:0] mdr,
  output logic        r,
  output logic        busy,
  output logic        err,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  output logic [1:0]  mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic        rw_q;
  logic        size_q;
  logic [15:0] mar_nx;
  logic        timeout_hit;

  // The alignment check must see the address this access will actually use.
  assign mar_nx      = ld_mar ? mar_in : mar;
  assign timeout_hit = (cnt == 8'(TIMEOUT - 1)) && !mem_ready;

  assign mem_addr  = {mar[15:1], 1'b0};
  assign mem_wdata = size_q ? mdr : {mdr[7:0], mdr[7:0]};

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nx = state;
    mem_en   = 1'b0;
    busy     = 1'b0;
    r        = 1'b0;
    mem_we   = 2'b00;
    unique case (state)
      IDLE: begin
        if (mio_en) state_nx = ACCESS;
      end
      ACCESS: begin
        mem_en = 1'b1;
        busy   = 1'b1;
        if (rw_q) begin
          if (size_q) mem_we = 2'b11;
          else        mem_we = mar[0] ? 2'b10 : 2'b01;
        end
        if (mem_ready || timeout_hit) state_nx = DONE;
      end
      DONE: begin
        r        = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mar    <= '0;
      mdr    <= '0;
      err    <= 1'b0;
      cnt    <= '0;
      rw_q   <= 1'b0;
      size_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (ld_mar) mar <= mar_in;
          if (ld_mdr) mdr <= mdr_in;
          if (mio_en) begin
            rw_q   <= r_w;
            size_q <= data_size;
            if (data_size && mar_nx[0]) err <= 1'b1;
          end
        end
        ACCESS: begin
          // MAR/MDR are frozen here; only a completing read may write MDR.
          if (mem_ready) begin
            if (!rw_q) mdr <= mem_rdata;
          end else begin
            cnt <= cnt + 8'd1;
            if (timeout_hit) err <= 1'b1;
          end
        end
        DONE: begin
          if (ld_mar) mar <= mar_in;
          if (ld_mdr) mdr <= mdr_in;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// Self-checking bench for lc3b_mem_ctrl: directed scenarios plus randomized transactions
// checked against a transaction-level expectation computed per access.
module tb_lc3b_mem_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_mar = 1'b0, ld_mdr = 1'b0, mio_en = 1'b0, r_w = 1'b0, data_size = 1'b0;
  logic [15:0] mar_in = '0, mdr_in = '0, mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [15:0] mar, mdr, mem_addr, mem_wdata;
  logic        r, busy, err, mem_en;
  logic [1:0]  mem_we;

  int n_checks = 0;
  int n_errors = 0;
  logic err_m = 1'b0;

  lc3b_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ld_mar(ld_mar), .mar_in(mar_in), .ld_mdr(ld_mdr), .mdr_in(mdr_in),
    .mio_en(mio_en), .r_w(r_w), .data_size(data_size),
    .mar(mar), .mdr(mdr), .r(r), .busy(busy), .err(err),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete access: load MAR/MDR in IDLE, start, serve memory after `lat` ACCESS
  // cycles (lat >= TIMEOUT means memory never answers), then check DONE and the IDLE after it.
  task automatic do_access(input logic [15:0] addr, input logic [15:0] wd, input logic rw,
                           input logic sz, input int lat, input logic [15:0] rd, input bit poke);
    int          n_acc;
    bit          timed_out;
    logic [1:0]  exp_we;
    logic [15:0] exp_wdata, exp_mdr, new_mar;
    bit          do_ld;

    ld_mar = 1'b1; mar_in = addr; ld_mdr = 1'b1; mdr_in = wd;
    step();
    check("ld_mar_idle", mar, addr);
    check("ld_mdr_idle", mdr, wd);
    check("idle_busy", busy, 0);

    ld_mar = 1'b0; ld_mdr = 1'b0;
    mio_en = 1'b1; r_w = rw; data_size = sz;
    step();
    // Request inputs change after the start edge; the access must keep its latched mode.
    mio_en = 1'b0; r_w = 1'($urandom); data_size = 1'($urandom);
    if (sz && addr[0]) err_m = 1'b1;

    timed_out = (lat >= TIMEOUT);
    n_acc     = timed_out ? TIMEOUT : lat + 1;
    exp_we    = !rw ? 2'b00 : (sz ? 2'b11 : 2'(1 << addr[0]));
    exp_wdata = sz ? wd : 16'(wd[7:0] * 16'h0101);

    for (int k = 0; k < n_acc; k++) begin
      check("acc_busy", busy, 1);
      check("acc_mem_en", mem_en, 1);
      check("acc_no_r", r, 0);
      check("acc_addr", mem_addr, {addr[15:1], 1'b0});
      check("acc_we", mem_we, exp_we);
      if (rw) check("acc_wdata", mem_wdata, exp_wdata);
      ld_mar = poke; mar_in = 16'h1234; ld_mdr = poke; mdr_in = 16'h5678;
      mem_ready = (k == lat);
      mem_rdata = (k == lat) ? rd : 16'($urandom);
      step();
      check("freeze_mar", mar, addr);
      if (k < n_acc - 1) check("freeze_mdr", mdr, wd);
    end
    if (timed_out) err_m = 1'b1;
    ld_mar = 1'b0; ld_mdr = 1'b0; mem_ready = 1'b0;

    exp_mdr = (rw || timed_out) ? wd : rd;
    check("done_r", r, 1);
    check("done_busy", busy, 0);
    check("done_mem_en", mem_en, 0);
    check("done_we", mem_we, 0);
    check("done_err", err, err_m);
    check("done_mdr", mdr, exp_mdr);

    do_ld = 1'($urandom);
    new_mar = 16'($urandom);
    ld_mar = do_ld; mar_in = new_mar;
    step();
    ld_mar = 1'b0;
    check("r_one_cycle", r, 0);
    check("done_ld_mar", mar, do_ld ? new_mar : addr);
    check("idle_err", err, err_m);
  endtask

  initial begin
    logic [15:0] rd_hold;

    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    check("rst_mar", mar, 0);
    check("rst_mdr", mdr, 0);
    check("rst_r", r, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_we", mem_we, 0);

    // Word read, memory answers in the 5th ACCESS cycle; loads poked during ACCESS.
    do_access(16'h3000, 16'h0000, 1'b0, 1'b1, 4, 16'hBEEF, 1'b1);
    // Byte write to the high byte.
    do_access(16'h4001, 16'h00A5, 1'b1, 1'b0, 2, 16'h0000, 1'b1);
    // Minimum latency: first-cycle ready, byte write to low byte.
    do_access(16'h4002, 16'h00C3, 1'b1, 1'b0, 0, 16'h0000, 1'b0);
    // Timeout: memory never answers; exactly TIMEOUT ACCESS cycles, MDR unchanged.
    do_access(16'h2000, 16'h1111, 1'b0, 1'b1, 100, 16'hDEAD, 1'b0);
    // Next access still works after a timeout.
    do_access(16'h2002, 16'h2222, 1'b0, 1'b1, 1, 16'h7777, 1'b0);

    // Back-to-back reads: after the k-th edge, r must be high exactly when k%3 == 2.
    ld_mar = 1'b1; mar_in = 16'h5000;
    step();
    ld_mar = 1'b0; r_w = 1'b0; data_size = 1'b1; mio_en = 1'b1; mem_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      mem_rdata = 16'($urandom);
      rd_hold   = mem_rdata;
      step();
      check("b2b_r", r, (k % 3 == 2) ? 1 : 0);
      if (k % 3 == 2) check("b2b_mdr", mdr, rd_hold);
    end
    mio_en = 1'b0; mem_ready = 1'b0;
    step();
    check("b2b_idle", busy, 0);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      do_access(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 17)), 16'($urandom), 1'($urandom));
    end

    // Reset in the 2nd ACCESS cycle.
    ld_mar = 1'b1; mar_in = 16'h6000; ld_mdr = 1'b1; mdr_in = 16'h9999;
    step();
    ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b1; r_w = 1'b0; data_size = 1'b1;
    step();
    mio_en = 1'b0;
    step();
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    err_m = 1'b0;
    check("mid_rst_mar", mar, 0);
    check("mid_rst_mdr", mdr, 0);
    check("mid_rst_r", r, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_mem_en", mem_en, 0);
    check("mid_rst_we", mem_we, 0);
    step();
    check("post_rst_no_r", r, 0);
    check("post_rst_busy", busy, 0);

    // Unaligned word read: err set, access served at the aligned address.
    do_access(16'h0003, 16'h0000, 1'b0, 1'b1, 1, 16'h4321, 1'b0);
    check("unaligned_err", err, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
